// File: rtl/block_loader.sv
// block_loader: assembles a hash state from chunks into a fill buffer and
// broadcasts each completed state for BCAST_COUNT accepted cycles, double-buffered.
module block_loader #(
  parameter int CHUNK_W = 8,
  parameter int STATE_W = 352,
  parameter int BCAST_COUNT = 16,
  localparam int NUM_CHUNKS = STATE_W / CHUNK_W,
  localparam int FW = $clog2(NUM_CHUNKS + 1),
  localparam int BW = BCAST_COUNT > 1 ? $clog2(BCAST_COUNT) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               writeValid,
  input  logic [CHUNK_W-1:0] blockData,
  output logic               writeReady,
  input  logic               hold,
  output logic               validOut,
  output logic               newBlock,
  output logic               lastBroadcast,
  output logic [STATE_W-1:0] initialState
);
  typedef enum logic {IDLE, BCAST} state_t;
  state_t state, state_n;
  logic [FW-1:0] fcnt;
  logic [BW-1:0] bcnt;
  logic [STATE_W-1:0] fbuf;
  logic full, step, xfer;
  always_comb begin
    full = fcnt == FW'(NUM_CHUNKS);
    writeReady = !full;
    validOut = state == BCAST;
    newBlock = validOut && bcnt == '0;
    lastBroadcast = validOut && bcnt == BW'(BCAST_COUNT - 1);
    step = validOut && !hold;
    xfer = full && (!validOut || (lastBroadcast && !hold));
    state_n = xfer ? BCAST : (step && lastBroadcast) ? IDLE : state;
  end
  // chunks shift in from the LSB end so chunk 0 ends up in the top bits
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      fcnt <= '0;
      bcnt <= '0;
      fbuf <= '0;
      initialState <= '0;
    end else begin
      state <= state_n;
      if (xfer) begin
        fcnt <= '0;
        bcnt <= '0;
        initialState <= fbuf;
      end else begin
        if (writeValid && !full) begin
          fcnt <= fcnt + FW'(1);
          fbuf <= STATE_W'({fbuf, blockData});
        end
        if (step && !lastBroadcast) bcnt <= bcnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_block_loader.sv
// tb_block_loader: scoreboard bench for block_loader at default parameters
// plus a small-parameter instance.
module tb_block_loader;
  typedef struct {
    logic [351:0] st;
    logic nb;
    logic lb;
  } exp_t;
  exp_t sb[$];
  int pass_cnt = 0;
  int total_cnt = 0;
  logic clk = 0;
  logic rst = 0;
  logic writeValid = 0;
  logic [7:0] blockData = 0;
  logic writeReady, hold = 0, validOut, newBlock, lastBroadcast;
  logic [351:0] initialState;
  logic wv2 = 0;
  logic [31:0] bd2 = 0;
  logic wr2, vo2, nb2, lb2;
  logic [63:0] is2;

  block_loader dut (
    .clk(clk), .rst(rst), .writeValid(writeValid), .blockData(blockData),
    .writeReady(writeReady), .hold(hold), .validOut(validOut), .newBlock(newBlock),
    .lastBroadcast(lastBroadcast), .initialState(initialState)
  );
  block_loader #(.CHUNK_W(32), .STATE_W(64), .BCAST_COUNT(1)) dut2 (
    .clk(clk), .rst(rst), .writeValid(wv2), .blockData(bd2),
    .writeReady(wr2), .hold(1'b0), .validOut(vo2), .newBlock(nb2),
    .lastBroadcast(lb2), .initialState(is2)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst && validOut && !hold) begin
      total_cnt++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: broadcast with empty scoreboard state=%h", initialState);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (initialState !== e.st || newBlock !== e.nb || lastBroadcast !== e.lb)
          $display("FAIL sb_bcast: got state=%h nb=%b lb=%b, want state=%h nb=%b lb=%b",
                   initialState, newBlock, lastBroadcast, e.st, e.nb, e.lb);
        else pass_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_block(input logic [351:0] s);
    for (int i = 0; i < 16; i++) sb.push_back('{st: s, nb: i == 0, lb: i == 15});
  endtask

  task automatic put(input logic [7:0] d);
    int n = 0;
    writeValid = 1;
    blockData = d;
    while (!writeReady && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) begin
      total_cnt++;
      $display("FAIL put_timeout: writeReady=%b after %0d cycles, want 1", writeReady, n);
    end
    tick();
    writeValid = 0;
  endtask

  task automatic wait_idle(input string nm, input int want_sb);
    int n = 0;
    while (validOut && n < 100) begin
      tick();
      n++;
    end
    total_cnt++;
    if (validOut !== 1'b0 || sb.size() != want_sb)
      $display("FAIL %s_idle: validOut=%b sb_left=%0d, want 0 and %0d", nm, validOut, sb.size(), want_sb);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 0;
    tick();
    tick();
    total_cnt++;
    if ({writeReady, validOut, newBlock, lastBroadcast} !== 4'b1000 || initialState !== '0)
      $display("FAIL reset_vals: wr/vo/nb/lb=%b state=%h, want 1000 and 0",
               {writeReady, validOut, newBlock, lastBroadcast}, initialState);
    else pass_cnt++;
    rst = 1;
  endtask

  task automatic test_single();
    logic [351:0] s = '0;
    int n = 0;
    for (int k = 1; k <= 44; k++) s = {s[343:0], 8'(k)};
    push_block(s);
    for (int k = 1; k <= 44; k++) put(8'(k));
    total_cnt++;
    if (writeReady !== 1'b0) $display("FAIL single_full: writeReady=%b want 0", writeReady);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (writeReady !== 1'b1 || validOut !== 1'b1 || newBlock !== 1'b1)
      $display("FAIL single_xfer: wr=%b vo=%b nb=%b want 1 1 1", writeReady, validOut, newBlock);
    else pass_cnt++;
    while (validOut && n < 100) begin
      tick();
      n++;
    end
    total_cnt++;
    if (n != 16) $display("FAIL single_len: validOut cycles=%0d want 16", n);
    else pass_cnt++;
    wait_idle("single", 0);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    logic bad = 0;
    push_block({44{8'hAA}});
    for (int k = 0; k < 44; k++) put(8'hAA);
    tick();
    total_cnt++;
    if (writeReady !== 1'b1 || newBlock !== 1'b1)
      $display("FAIL b2b_xfer_a: wr=%b nb=%b want 1 1", writeReady, newBlock);
    else pass_cnt++;
    hold = 1;
    push_block({44{8'h55}});
    for (int k = 0; k < 44; k++) put(8'h55);
    total_cnt++;
    if (writeReady !== 1'b0 || validOut !== 1'b1 || initialState !== {44{8'hAA}})
      $display("FAIL b2b_b_full: wr=%b vo=%b state=%h want 0 1 all-AA", writeReady, validOut, initialState);
    else pass_cnt++;
    hold = 0;
    while (!lastBroadcast && n < 100) begin
      if (writeReady) bad = 1;
      tick();
      n++;
    end
    total_cnt++;
    if (bad || writeReady !== 1'b0 || lastBroadcast !== 1'b1)
      $display("FAIL b2b_wr_low: early_ready=%b wr=%b lb=%b want 0 0 1", bad, writeReady, lastBroadcast);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (validOut !== 1'b1 || newBlock !== 1'b1 || initialState !== {44{8'h55}} || writeReady !== 1'b1)
      $display("FAIL b2b_next: vo=%b nb=%b wr=%b state=%h want 1 1 1 all-55",
               validOut, newBlock, writeReady, initialState);
    else pass_cnt++;
    wait_idle("b2b", 0);
  endtask

  task automatic test_hold();
    logic [351:0] s = '0;
    logic [351:0] snap;
    int n = 0;
    int last_at = -1;
    logic bad = 0;
    for (int k = 0; k < 44; k++) s = {s[343:0], 8'(k * 3 + 7)};
    push_block(s);
    for (int k = 0; k < 44; k++) put(8'(k * 3 + 7));
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      n++;
    end
    snap = initialState;
    hold = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n++;
      if (validOut !== 1'b1 || initialState !== snap || newBlock !== 1'b0 || lastBroadcast !== 1'b0) bad = 1;
    end
    total_cnt++;
    if (bad) $display("FAIL hold_frozen: vo=%b nb=%b lb=%b state changed=%b", validOut, newBlock,
                      lastBroadcast, initialState !== snap);
    else pass_cnt++;
    hold = 0;
    while (validOut && n < 100) begin
      if (lastBroadcast) last_at = n;
      tick();
      n++;
    end
    total_cnt++;
    if (n != 19 || last_at != 18)
      $display("FAIL hold_len: vo_cycles=%0d last_at=%0d want 19 18", n, last_at);
    else pass_cnt++;
    wait_idle("hold", 0);
  endtask

  task automatic test_sparse();
    logic [351:0] s = '0;
    for (int k = 1; k <= 44; k++) s = {s[343:0], 8'(k)};
    push_block(s);
    for (int k = 1; k <= 44; k++) begin
      put(8'(k));
      if (k < 44) tick();
    end
    total_cnt++;
    if (writeReady !== 1'b0 || validOut !== 1'b0)
      $display("FAIL sparse_full: wr=%b vo=%b want 0 0", writeReady, validOut);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (validOut !== 1'b1 || newBlock !== 1'b1)
      $display("FAIL sparse_xfer: vo=%b nb=%b want 1 1", validOut, newBlock);
    else pass_cnt++;
    wait_idle("sparse", 0);
  endtask

  task automatic test_reset_mid();
    logic [351:0] s = '0;
    for (int k = 0; k < 20; k++) put(8'hF0);
    rst = 0;
    #1;
    total_cnt++;
    if (writeReady !== 1'b1 || validOut !== 1'b0 || initialState !== '0)
      $display("FAIL rst_fill: wr=%b vo=%b state=%h want 1 0 0", writeReady, validOut, initialState);
    else pass_cnt++;
    tick();
    rst = 1;
    for (int k = 0; k < 44; k++) s = {s[343:0], 8'(200 - k)};
    push_block(s);
    for (int k = 0; k < 44; k++) put(8'(200 - k));
    tick();
    for (int i = 0; i < 7; i++) tick();
    rst = 0;
    sb.delete();
    #1;
    total_cnt++;
    if ({writeReady, validOut, newBlock, lastBroadcast} !== 4'b1000 || initialState !== '0)
      $display("FAIL rst_bcast: wr/vo/nb/lb=%b state=%h want 1000 and 0",
               {writeReady, validOut, newBlock, lastBroadcast}, initialState);
    else pass_cnt++;
    tick();
    rst = 1;
    s = '0;
    for (int k = 0; k < 44; k++) s = {s[343:0], 8'(k ^ 8'h3C)};
    push_block(s);
    for (int k = 0; k < 44; k++) put(8'(k ^ 8'h3C));
    tick();
    total_cnt++;
    if (validOut !== 1'b1 || newBlock !== 1'b1 || initialState !== s)
      $display("FAIL rst_reload: vo=%b nb=%b state=%h want 1 1 %h", validOut, newBlock, initialState, s);
    else pass_cnt++;
    wait_idle("rst", 0);
  endtask

  task automatic test_variant();
    wv2 = 1;
    bd2 = 32'hDEADBEEF;
    tick();
    bd2 = 32'h01234567;
    tick();
    wv2 = 0;
    total_cnt++;
    if (wr2 !== 1'b0 || vo2 !== 1'b0) $display("FAIL var_full: wr=%b vo=%b want 0 0", wr2, vo2);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (vo2 !== 1'b1 || nb2 !== 1'b1 || lb2 !== 1'b1 || is2 !== 64'hDEADBEEF01234567)
      $display("FAIL var_bcast: vo=%b nb=%b lb=%b state=%h want 1 1 1 deadbeef01234567", vo2, nb2, lb2, is2);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (vo2 !== 1'b0 || wr2 !== 1'b1) $display("FAIL var_idle: vo=%b wr=%b want 0 1", vo2, wr2);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_sparse();
    test_reset_mid();
    test_variant();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/block_loader.md
# block_loader

Parametrised, double-buffered successor to the block store in the hashing front end. It assembles an initial hash state from a stream of fixed-width chunks into a fill buffer. It transfers the completed state to a broadcast register and presents that state to the hash cores for a programmable number of valid cycles, with downstream back-pressure. The next block loads while the current one is being broadcast, so there is no dead time between blocks.

## Interface
- CHUNK_W, 8: width of one input chunk in bits.
- STATE_W, 352: width of the assembled state. Must be an integer multiple of CHUNK_W.
- BCAST_COUNT, 16: number of accepted broadcast cycles per block. Must be ≥1.
- NUM_CHUNKS, derived STATE_W/CHUNK_W: chunks per block (44 at defaults).
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- writeValid  in  1  blockData carries a chunk this cycle.
- blockData  in  CHUNK_W  input chunk.
- writeReady  out  1  fill buffer can accept a chunk.
- hold  in  1  downstream stall; freezes the broadcast counter.
- validOut  out  1  initialState is a valid broadcast.
- newBlock  out  1  this broadcast is the first (index 0) of a block.
- lastBroadcast  out  1  this broadcast is index BCAST_COUNT-1.
- initialState  out  STATE_W  broadcast register contents.

## Operation
- **Write acceptance:** a write is accepted on a rising edge when writeValid && writeReady. Otherwise blockData is ignored.
- **Fill side:** a fill counter fcnt runs 0..NUM_CHUNKS; its width is $clog2(NUM_CHUNKS+1).
  - writeReady = (fcnt < NUM_CHUNKS). It depends on registered state only, never on writeValid.
  - Chunks are packed MSB-first: chunk k lands at bits [STATE_W-1-k*CHUNK_W -: CHUNK_W].
  - Gaps in writeValid are allowed and stall the fill without loss.
  - fcnt == NUM_CHUNKS means the fill buffer is FULL.
- **Transfer:** occurs on an edge where FULL && (broadcaster IDLE || (broadcaster BCAST && lastBroadcast && !hold)).
  - The fill buffer is copied to the broadcast register.
  - fcnt is cleared to 0.
  - The broadcast counter bcnt is cleared to 0.
  - The broadcaster enters BCAST.
- **Broadcaster FSM:**
  - IDLE: validOut=0. Moves to BCAST on a transfer.
  - BCAST: validOut=1, newBlock=(bcnt==0), lastBroadcast=(bcnt==BCAST_COUNT-1).
  - A broadcast is accepted when !hold; the counter then advances.
  - When !hold && lastBroadcast: go to BCAST with a new block if a transfer fires the same edge, else go to IDLE.
- **Hold behaviour:** while hold=1, bcnt, initialState, newBlock and lastBroadcast are frozen. validOut stays 1. hold is ignored in IDLE.
- **Width rule:** bcnt is max(1,$clog2(BCAST_COUNT)) bits and never wraps past BCAST_COUNT-1.
- **Simultaneous events:** a chunk write and a broadcast step are independent and may occur on the same edge. A write is never accepted on the transfer edge, because writeReady=0 while FULL.

## Timing
- **Reset values:** writeReady=1, validOut=0, newBlock=0, lastBroadcast=0, initialState=0, fcnt=0, bcnt=0, FSM=IDLE.
- **Asserting rst mid-operation:** clears everything immediately and discards a partial fill and the current broadcast. The first write is accepted at the first edge after rst deasserts.
- **Load latency:** last chunk accepted at edge E → FULL after E → transfer at E+1 → validOut=1 and newBlock=1 after E+1.
- **Fill time:** with writeValid held high, the minimum is NUM_CHUNKS cycles.
- **Back-to-back:**
  - If the next block is FULL before lastBroadcast is accepted, newBlock follows lastBroadcast in the very next cycle with no IDLE bubble.
  - writeReady returns to 1 the cycle after the transfer.
- **Broadcast length:** exactly BCAST_COUNT accepted broadcasts per block, plus any hold cycles.
- **Output stability:** all outputs are registered or decoded from registers only; there is no combinational path from inputs to outputs.

## Test plan
- **Single block:** after reset, drive 44 chunks 0x01..0x2C continuously.
  - writeReady falls after the 44th chunk and returns to 1 one cycle later.
  - validOut is high for exactly 16 cycles with initialState = 0x0102…2B2C.
  - newBlock is 1 only on the first of those cycles, lastBroadcast only on the 16th; then IDLE.
- **Back-to-back:** load block A (all 0xAA), then immediately stream block B (all 0x55).
  - B fills during A's broadcast.
  - writeReady=0 from B's full until A's lastBroadcast cycle.
  - The cycle after A's lastBroadcast shows validOut=1, newBlock=1, initialState = all 0x55.
- **Hold:** assert hold for 3 cycles when bcnt=5.
  - validOut stays 1 and initialState is unchanged.
  - lastBroadcast arrives 3 cycles late; the total count of accepted broadcasts is still 16.
- **Sparse writes:** toggle writeValid on alternate cycles.
  - The state is assembled identically to a continuous load.
  - Transfer occurs one cycle after the 44th accepted chunk.
- **Reset mid-operation:** assert rst after 20 chunks and again at bcnt=7.
  - All outputs return to reset values immediately.
  - A fresh 44-chunk load then produces a correct block with newBlock=1.
- **Parameter variant:** CHUNK_W=32, STATE_W=64, BCAST_COUNT=1, chunks 0xDEADBEEF then 0x01234567.
  - One validOut cycle with newBlock=1 and lastBroadcast=1, initialState=0xDEADBEEF01234567.
